// File: rtl/tbu_if.sv
// Bus between the Viterbi path-metric unit and the traceback unit (tbu).
// Handshake: upstream may pulse valid_i only while ready_o is high; bit_valid_o is a one-cycle strobe.
interface tbu_if #(
  parameter int TBL      = 15,
  parameter int PM_WIDTH = 8
);
  localparam int AW = $clog2(TBL);

  logic                valid_i;
  logic [PM_WIDTH-1:0] pm_s0_i;
  logic [PM_WIDTH-1:0] pm_s1_i;
  logic [PM_WIDTH-1:0] pm_s2_i;
  logic [PM_WIDTH-1:0] pm_s3_i;
  logic [3:0]          read_data_i;
  logic [AW-1:0]       read_addr_o;
  logic                ready_o;
  logic                bit_o;
  logic                bit_valid_o;
  logic                overrun_o;

  modport master (
    output valid_i, pm_s0_i, pm_s1_i, pm_s2_i, pm_s3_i, read_data_i,
    input  read_addr_o, ready_o, bit_o, bit_valid_o, overrun_o
  );

  modport slave (
    input  valid_i, pm_s0_i, pm_s1_i, pm_s2_i, pm_s3_i, read_data_i,
    output read_addr_o, ready_o, bit_o, bit_valid_o, overrun_o
  );
endinterface

// File: rtl/tbu.sv
// Traceback unit for the 4-state (K=3) Viterbi decoder: walks decision memory newest to oldest, one bit per traceback.
// Define TBU_FIXED_START_EN to always start from state 0 instead of the minimum path metric.
module tbu #(
  parameter int TBL      = 15,
  parameter int PM_WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  tbu_if.slave       bus,
  output logic [1:0] state_o
);
  localparam int AW = $clog2(TBL);
  localparam int FW = $clog2(TBL + 1);
  localparam logic [AW-1:0] ADDR_TOP    = AW'(TBL - 1);
  localparam logic [AW-1:0] ADDR_START  = AW'(TBL - 2);
  localparam logic [FW-1:0] FILL_MAX    = FW'(TBL);
  localparam logic [FW-1:0] FILL_LAUNCH = FW'(TBL - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, TRACE = 2'd2} state_t;

  state_t        state_q, state_d;
  logic [FW-1:0] fill_q, fill_d;
  logic [1:0]    cur_q, cur_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          bit_q, bit_d;
  logic          bit_valid_q, bit_valid_d;
  logic          overrun_q, overrun_d;
  logic [1:0]    start_s;

`ifdef TBU_FIXED_START_EN
  assign start_s = 2'd0;
`else
  logic [PM_WIDTH-1:0] best_pm;

  // Strict less-than keeps the lowest index on ties.
  always_comb begin
    start_s = 2'd0;
    best_pm = bus.pm_s0_i;
    if (bus.pm_s1_i < best_pm) begin best_pm = bus.pm_s1_i; start_s = 2'd1; end
    if (bus.pm_s2_i < best_pm) begin best_pm = bus.pm_s2_i; start_s = 2'd2; end
    if (bus.pm_s3_i < best_pm) begin best_pm = bus.pm_s3_i; start_s = 2'd3; end
  end
`endif

  always_comb begin
    state_d     = state_q;
    fill_d      = fill_q;
    cur_d       = cur_q;
    addr_d      = addr_q;
    bit_d       = bit_q;
    bit_valid_d = 1'b0;
    overrun_d   = overrun_q;

    if (bus.valid_i && fill_q != FILL_MAX) fill_d = fill_q + FW'(1);
    if (bus.valid_i && state_q != IDLE)    overrun_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (bus.valid_i && (fill_q == FILL_LAUNCH || fill_q == FILL_MAX)) state_d = START;
      end
      START: begin
        cur_d   = {start_s[0], bus.read_data_i[start_s]};
        addr_d  = ADDR_START;
        state_d = TRACE;
      end
      TRACE: begin
        // Predecessor: shift the older bit up, pull the decision bit in below.
        cur_d = {cur_q[0], bus.read_data_i[cur_q]};
        if (addr_q > AW'(1)) begin
          addr_d = addr_q - AW'(1);
        end else begin
          bit_d       = cur_d[1];
          bit_valid_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      fill_q      <= '0;
      cur_q       <= 2'd0;
      addr_q      <= ADDR_TOP;
      bit_q       <= 1'b0;
      bit_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      fill_q      <= fill_d;
      cur_q       <= cur_d;
      addr_q      <= addr_d;
      bit_q       <= bit_d;
      bit_valid_q <= bit_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign bus.read_addr_o = (state_q == TRACE) ? addr_q : ADDR_TOP;
  assign bus.ready_o     = (state_q == IDLE);
  assign bus.bit_o       = bit_q;
  assign bus.bit_valid_o = bit_valid_q;
  assign bus.overrun_o   = overrun_q;
  assign state_o         = state_q;
endmodule

// File: tb/tb_tbu.sv
// Self-checking bench for tbu: models the decision memory and path metrics, predicts each decoded bit.
module tb_tbu;
  localparam int TBL = 15;
  localparam int PW  = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tbu_if #(.TBL(TBL), .PM_WIDTH(PW)) bus ();
  logic [1:0] state_dbg;

  tbu #(.TBL(TBL), .PM_WIDTH(PW)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus),
    .state_o(state_dbg)
  );

  // Decision memory: index 0 oldest, TBL-1 newest.
  logic [3:0] mem [TBL];
  logic [3:0] wdata;

  always @(posedge clk) begin
    if (bus.valid_i) begin
      for (int i = 0; i < TBL - 1; i++) mem[i] <= mem[i+1];
      mem[TBL-1] <= wdata;
    end
  end

  assign bus.read_data_i = mem[bus.read_addr_o];

  int errors = 0;
  int checks = 0;
  int tb_fill = 0;
  logic [1:0] exp_q[$];   // {care, expected bit}
  logic [1:0] mon_e;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic model_bit();
    logic [1:0]    s;
    logic [3:0]    w;
    logic [PW-1:0] pm [4];
    logic [PW-1:0] best;
    pm[0] = bus.pm_s0_i; pm[1] = bus.pm_s1_i; pm[2] = bus.pm_s2_i; pm[3] = bus.pm_s3_i;
`ifdef TBU_FIXED_START_EN
    s = 2'd0;
    best = pm[0];
`else
    s = 2'd0;
    best = pm[0];
    for (int i = 1; i < 4; i++) if (pm[i] < best) begin best = pm[i]; s = 2'(i); end
`endif
    for (int a = TBL - 1; a >= 1; a--) begin
      w = mem[a];
      s = {s[0], w[s]};
    end
    return s[1];
  endfunction

  always @(negedge clk) begin
    if (bus.bit_valid_o) begin
      if (exp_q.size() == 0) begin
        check("bv_unexpected", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e[1]) check("bit_o", {31'd0, bus.bit_o}, {31'd0, mon_e[0]});
      end
    end
  end

  // Called at a negedge; returns at the next negedge, after the write edge.
  task automatic drive_valid(input logic [3:0] w, input logic launch, input logic care);
    wdata = w;
    bus.valid_i = 1'b1;
    @(negedge clk);
    bus.valid_i = 1'b0;
    if (tb_fill < TBL) tb_fill++;
    if (launch) exp_q.push_back({care, model_bit()});
  endtask

  task automatic set_pm(input logic [PW-1:0] p0, p1, p2, p3);
    bus.pm_s0_i = p0; bus.pm_s1_i = p1; bus.pm_s2_i = p2; bus.pm_s3_i = p3;
  endtask

  task automatic do_reset();
    bus.valid_i = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tb_fill = 0;
    @(negedge clk);
  endtask

  task automatic prime(input logic [3:0] w0, input logic [3:0] w1, input logic chk);
    for (int i = 0; i < TBL - 1; i++) begin
      drive_valid((i % 2 == 1) ? w1 : w0, 1'b0, 1'b0);
      if (chk) check("prime_ready", {31'd0, bus.ready_o}, 32'd1);
    end
  endtask

  // Starts at the negedge after launch edge E (START cycle).
  task automatic trace_check(input logic [3:0] exp_ovr);
    check("start_addr", {28'd0, bus.read_addr_o}, 32'd14);
    check("start_ready", {31'd0, bus.ready_o}, 32'd0);
    for (int k = 0; k < TBL - 2; k++) begin
      @(negedge clk);
      check("trace_addr", {28'd0, bus.read_addr_o}, 32'(13 - k));
      check("trace_ready", {31'd0, bus.ready_o}, 32'd0);
      check("trace_bv", {31'd0, bus.bit_valid_o}, 32'd0);
      check("trace_ovr", {31'd0, bus.overrun_o}, {28'd0, exp_ovr});
    end
    @(negedge clk);
    check("done_ready", {31'd0, bus.ready_o}, 32'd1);
    check("done_bv", {31'd0, bus.bit_valid_o}, 32'd1);
  endtask

  initial begin
    bus.valid_i = 1'b0;
    wdata = 4'h0;
    set_pm(8'd0, 8'd0, 8'd0, 8'd0);

    // Reset values
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_addr", {28'd0, bus.read_addr_o}, 32'd14);
    check("rst_ready", {31'd0, bus.ready_o}, 32'd1);
    check("rst_bv", {31'd0, bus.bit_valid_o}, 32'd0);
    check("rst_ovr", {31'd0, bus.overrun_o}, 32'd0);
    check("rst_bit", {31'd0, bus.bit_o}, 32'd0);
    check("rst_state", {30'd0, state_dbg}, 32'd0);

    // Zero decisions, PMs (0,4,4,4): 14 fills then launch
    set_pm(8'd0, 8'd4, 8'd4, 8'd4);
    prime(4'h0, 4'h0, 1'b1);
    drive_valid(4'h0, 1'b1, 1'b1);
    trace_check(4'd0);

    // All-ones decisions, PMs (5,5,5,0)
    do_reset();
    set_pm(8'd5, 8'd5, 8'd5, 8'd0);
    prime(4'hF, 4'hF, 1'b0);
    drive_valid(4'hF, 1'b1, 1'b1);
    trace_check(4'd0);

    // Tie between states 1 and 2, alternating decisions
    do_reset();
    set_pm(8'd3, 8'd0, 8'd0, 8'd7);
    prime(4'h5, 4'hA, 1'b0);
    drive_valid(4'h5, 1'b1, 1'b1);
    trace_check(4'd0);

    // Random words and metrics, back-to-back tracebacks at full rate
    do_reset();
    for (int r = 0; r < 3; r++) begin
      set_pm(PW'($urandom_range(0, 255)), PW'($urandom_range(0, 255)),
             PW'($urandom_range(0, 255)), PW'($urandom_range(0, 255)));
      if (r == 0) prime(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b0);
      drive_valid(4'($urandom_range(0, 15)), 1'b1, 1'b1);
      trace_check(4'd0);
    end

    // Overrun during a traceback
    do_reset();
    set_pm(8'd0, 8'd4, 8'd4, 8'd4);
    prime(4'h0, 4'h0, 1'b0);
    drive_valid(4'h0, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    drive_valid(4'h0, 1'b0, 1'b0);
    check("ovr_set", {31'd0, bus.overrun_o}, 32'd1);
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      check("ovr_hold", {31'd0, bus.overrun_o}, 32'd1);
    end
    drive_valid(4'h0, 1'b1, 1'b1);
    trace_check(4'd1);
    do_reset();
    check("ovr_clear", {31'd0, bus.overrun_o}, 32'd0);

    // Reset mid-trace at address 7
    set_pm(8'd0, 8'd4, 8'd4, 8'd4);
    prime(4'h0, 4'h0, 1'b0);
    drive_valid(4'h0, 1'b0, 1'b0);
    repeat (7) @(negedge clk);
    check("mid_addr", {28'd0, bus.read_addr_o}, 32'd7);
    rst_n = 1'b0;
    #1;
    check("mid_ready", {31'd0, bus.ready_o}, 32'd1);
    check("mid_addr_rst", {28'd0, bus.read_addr_o}, 32'd14);
    check("mid_state", {30'd0, state_dbg}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tb_fill = 0;
    @(negedge clk);
    set_pm(8'd5, 8'd5, 8'd5, 8'd0);
    prime(4'hF, 4'hF, 1'b1);
    drive_valid(4'hF, 1'b1, 1'b1);
    trace_check(4'd0);

    repeat (3) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
